// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: one MUL*/DIV*/REM* operation at a time.
// Latency: accept at edge N, oBusy after edges N..N+31, oDone pulse after edge N+32.
// Backpressure: iStart is ignored while busy; a new request may be issued in the DONE cycle.
//
// Ports:
//   iCLK      clock, rising edge
//   iRST      asynchronous active-low reset
//   iStart    request strobe, accepted in IDLE or DONE
//   iControl  5-bit ALU control code (OPMUL..OPREMU), latched on accept
//   iA, iB    rs1 / rs2 operands, latched on accept
//   oBusy     high while iterating
//   oDone     one-cycle completion pulse
//   oResult   32-bit result, held until the next completion
module mdu_seq (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [4:0]  iControl,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oResult
);

  // ALU control codes shared with the combinational ALU (Parametros.v)
  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHU  = 5'd13;
  localparam logic [4:0] OPMULHSU = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;
  localparam logic [4:0] OPREM    = 5'd17;
  localparam logic [4:0] OPREMU   = 5'd18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Which part of the finished datapath becomes oResult
  typedef enum logic [1:0] {
    SEL_PLO = 2'd0,
    SEL_PHI = 2'd1,
    SEL_QUO = 2'd2,
    SEL_REM = 2'd3
  } sel_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;

  // Latched operation context
  logic [4:0]  cnt;
  logic        div_r;
  sel_t        sel_r;
  logic        neg_q;       // negate product / quotient at the end
  logic        neg_r;       // negate remainder at the end
  logic        spec_r;      // result fixed at accept time
  logic [31:0] spec_res_r;

  // Shared iteration registers.
  // Multiply: {acc_hi, acc_lo} is the 64-bit product, acc_lo starts as the multiplier.
  // Divide:   acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opb;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful together with accept)
  // ---------------------------------------------------------------------------
  logic        dec_vld;
  logic        dec_div;
  logic        dec_a_sgn;
  logic        dec_b_sgn;
  sel_t        dec_sel;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        spec_hit;
  logic [31:0] spec_res;

  always_comb begin
    dec_vld   = 1'b1;
    dec_div   = 1'b0;
    dec_a_sgn = 1'b0;
    dec_b_sgn = 1'b0;
    dec_sel   = SEL_PLO;
    case (iControl)
      OPMUL: begin
        dec_a_sgn = 1'b1;
        dec_b_sgn = 1'b1;
      end
      OPMULH: begin
        dec_a_sgn = 1'b1;
        dec_b_sgn = 1'b1;
        dec_sel   = SEL_PHI;
      end
      OPMULHSU: begin
        dec_a_sgn = 1'b1;
        dec_sel   = SEL_PHI;
      end
      OPMULHU: begin
        dec_sel   = SEL_PHI;
      end
      OPDIV: begin
        dec_div   = 1'b1;
        dec_a_sgn = 1'b1;
        dec_b_sgn = 1'b1;
        dec_sel   = SEL_QUO;
      end
      OPDIVU: begin
        dec_div   = 1'b1;
        dec_sel   = SEL_QUO;
      end
      OPREM: begin
        dec_div   = 1'b1;
        dec_a_sgn = 1'b1;
        dec_b_sgn = 1'b1;
        dec_sel   = SEL_REM;
      end
      OPREMU: begin
        dec_div   = 1'b1;
        dec_sel   = SEL_REM;
      end
      default: begin
        dec_vld   = 1'b0;
      end
    endcase
  end

  assign a_neg = dec_a_sgn & iA[31];
  assign b_neg = dec_b_sgn & iB[31];
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
  assign a_mag = a_neg ? (32'd0 - iA) : iA;
  assign b_mag = b_neg ? (32'd0 - iB) : iB;

  // Cases whose result is known up front. The unit still runs the full
  // iteration count so the timing never depends on the operands.
  always_comb begin
    spec_hit = 1'b0;
    spec_res = 32'd0;
    if (!dec_vld) begin
      spec_hit = 1'b1;
    end else if (dec_div && (iB == 32'd0)) begin
      spec_hit = 1'b1;
      spec_res = (dec_sel == SEL_QUO) ? 32'hFFFF_FFFF : iA;
    end else if (dec_div && dec_a_sgn &&
                 (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF)) begin
      spec_hit = 1'b1;
      spec_res = (dec_sel == SEL_QUO) ? 32'h8000_0000 : 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_ge    = (div_shift >= {1'b0, opb});
  // When div_ge holds the true difference is below the divisor, so 32 bits suffice
  assign div_diff  = div_shift[31:0] - opb;

  always_comb begin
    if (div_r) begin
      hi_nxt = div_ge ? div_diff : div_shift[31:0];
      lo_nxt = {acc_lo[30:0], div_ge};
    end else begin
      hi_nxt = mul_sum[32:1];
      lo_nxt = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select, taken from the final step's values
  // ---------------------------------------------------------------------------
  logic [63:0] prod_raw;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_fin;

  assign prod_raw = {hi_nxt, lo_nxt};
  assign prod_fix = neg_q ? (64'd0 - prod_raw) : prod_raw;
  assign quo_fix  = neg_q ? (32'd0 - lo_nxt) : lo_nxt;
  assign rem_fix  = neg_r ? (32'd0 - hi_nxt) : hi_nxt;

  always_comb begin
    res_fin = 32'd0;
    case (sel_r)
      SEL_PLO: res_fin = prod_fix[31:0];
      SEL_PHI: res_fin = prod_fix[63:32];
      SEL_QUO: res_fin = quo_fix;
      SEL_REM: res_fin = rem_fix;
      default: res_fin = 32'd0;
    endcase
    if (spec_r) begin
      res_fin = spec_res_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign accept = iStart && ((state == IDLE) || (state == DONE));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        oBusy = 1'b1;
        if (cnt == 5'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        oDone     = 1'b1;
        state_nxt = iStart ? CALC : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt        <= 5'd0;
      div_r      <= 1'b0;
      sel_r      <= SEL_PLO;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      spec_r     <= 1'b0;
      spec_res_r <= 32'd0;
      acc_hi     <= 32'd0;
      acc_lo     <= 32'd0;
      opb        <= 32'd0;
      oResult    <= 32'd0;
    end else if (accept) begin
      cnt        <= 5'd31;
      div_r      <= dec_div;
      sel_r      <= dec_sel;
      neg_q      <= a_neg ^ b_neg;
      neg_r      <= a_neg;
      spec_r     <= spec_hit;
      spec_res_r <= spec_res;
      acc_hi     <= 32'd0;
      acc_lo     <= a_mag;
      opb        <= b_mag;
    end else if (state == CALC) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      // cnt==0 marks the 32nd step; its result is committed on this same edge
      if (cnt == 5'd0) begin
        oResult <= res_fin;
      end else begin
        cnt <= cnt - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table plus handshake, back-to-back and reset sequences.
module tb_mdu_seq;

  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHU  = 5'd13;
  localparam logic [4:0] OPMULHSU = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;
  localparam logic [4:0] OPREM    = 5'd17;
  localparam logic [4:0] OPREMU   = 5'd18;
  localparam logic [4:0] OPADD    = 5'd3;

  logic        iCLK;
  logic        iRST;
  logic        iStart;
  logic [4:0]  iControl;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_seq dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iStart   (iStart),
    .iControl (iControl),
    .iA       (iA),
    .iB       (iB),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oResult  (oResult)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE and follow it to completion.
  // lat: edges after the accepting edge until oDone is seen (-1 on timeout).
  // busy_n: sampled cycles with oBusy high, including the one right after accept.
  // poke_at: if >0, a MUL 3x4 strobe is presented before that edge while busy.
  task automatic run_op(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at,
                        output logic [31:0] res, output int lat, output int busy_n,
                        output logic done_after, output logic busy_after,
                        output logic [31:0] res_after);
    @(negedge iCLK);
    iStart   = 1'b1;
    iControl = ctl;
    iA       = a;
    iB       = b;
    @(posedge iCLK);
    @(negedge iCLK);
    iStart   = 1'b0;
    iControl = OPMUL;
    iA       = $urandom;
    iB       = $urandom;
    lat      = -1;
    res      = 32'd0;
    busy_n   = oBusy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke_at) begin
        iStart   = 1'b1;
        iControl = OPMUL;
        iA       = 32'd3;
        iB       = 32'd4;
      end else begin
        iStart = 1'b0;
      end
      @(posedge iCLK);
      @(negedge iCLK);
      if (oBusy) busy_n++;
      if (oDone) begin
        lat = k;
        res = oResult;
        break;
      end
    end
    iStart = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    done_after = oDone;
    busy_after = oBusy;
    res_after  = oResult;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] res_after;
    logic        done_after;
    logic        busy_after;
    int          lat;
    int          busy_n;
    int          gap;
    int          spurious;

    vecs[0]  = '{OPMUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{OPMULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{OPMULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{OPMULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{OPDIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{OPREM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{OPDIVU,   32'hFFFF_FFFE, 32'h0000_0003, 32'h5555_5554};
    vecs[7]  = '{OPREMU,   32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002};
    vecs[8]  = '{OPDIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{OPREMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[10] = '{OPDIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{OPREM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{OPDIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[13] = '{OPREM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
    vecs[14] = '{OPMULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[15] = '{OPADD,    32'h0000_0005, 32'h0000_0007, 32'h0000_0000};
    vecs[16] = '{OPMUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[17] = '{OPMULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};

    iStart   = 1'b0;
    iControl = 5'd0;
    iA       = 32'd0;
    iB       = 32'd0;
    iRST     = 1'b1;
    #1 iRST  = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check32("reset_busy",   {31'd0, oBusy}, 32'd0);
    check32("reset_done",   {31'd0, oDone}, 32'd0);
    check32("reset_result", oResult,        32'd0);
    iRST = 1'b1;

    // Table of single operations
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, 0, res, lat, busy_n, done_after, busy_after, res_after);
      check32($sformatf("vec%0d_result", i), res, vecs[i].exp);
      checki($sformatf("vec%0d_latency", i), lat, 32);
      checki($sformatf("vec%0d_busy_cycles", i), busy_n, 32);
      check32($sformatf("vec%0d_done_pulse", i), {31'd0, done_after}, 32'd0);
      check32($sformatf("vec%0d_result_hold", i), res_after, vecs[i].exp);
    end

    // Strobe while busy is ignored: DIV 100/7 with MUL 3x4 poked mid-operation
    run_op(OPDIV, 32'd100, 32'd7, 12, res, lat, busy_n, done_after, busy_after, res_after);
    check32("poke_result", res, 32'h0000_000E);
    checki("poke_latency", lat, 32);
    checki("poke_busy_cycles", busy_n, 32);
    check32("poke_no_queue_busy", {31'd0, busy_after}, 32'd0);
    check32("poke_no_queue_done", {31'd0, done_after}, 32'd0);

    // Back-to-back: iStart held through the DONE cycle
    @(negedge iCLK);
    iStart   = 1'b1;
    iControl = OPDIV;
    iA       = 32'd100;
    iB       = 32'd7;
    @(posedge iCLK);
    @(negedge iCLK);
    iControl = OPDIVU;
    iA       = 32'd1000;
    iB       = 32'd10;
    lat = -1;
    res = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge iCLK);
      @(negedge iCLK);
      if (oDone) begin
        lat = k;
        res = oResult;
        break;
      end
    end
    checki("b2b_first_latency", lat, 32);
    check32("b2b_first_result", res, 32'h0000_000E);
    gap = -1;
    for (int g = 1; g <= 40; g++) begin
      @(posedge iCLK);
      @(negedge iCLK);
      if (g == 1) begin
        iStart = 1'b0;
        check32("b2b_second_accepted", {31'd0, oBusy}, 32'd1);
      end
      if (oDone) begin
        gap = g;
        res = oResult;
        break;
      end
    end
    checki("b2b_done_spacing", gap, 33);
    check32("b2b_second_result", res, 32'h0000_0064);
    @(posedge iCLK);
    @(negedge iCLK);
    check32("b2b_idle_after", {30'd0, oBusy, oDone}, 32'd0);

    // Reset in the middle of a DIVU
    @(negedge iCLK);
    iStart   = 1'b1;
    iControl = OPDIVU;
    iA       = 32'hFFFF_FFFE;
    iB       = 32'd3;
    @(posedge iCLK);
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (10) @(posedge iCLK);
    @(negedge iCLK);
    check32("pre_reset_busy", {31'd0, oBusy}, 32'd1);
    iRST = 1'b0;
    #1;
    check32("abort_busy",   {31'd0, oBusy}, 32'd0);
    check32("abort_done",   {31'd0, oDone}, 32'd0);
    check32("abort_result", oResult,        32'd0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge iCLK);
      @(negedge iCLK);
      if (oDone || oBusy) spurious++;
    end
    checki("abort_no_pending_done", spurious, 0);
    run_op(OPMUL, 32'd2, 32'd3, 0, res, lat, busy_n, done_after, busy_after, res_after);
    check32("post_reset_result", res, 32'h0000_0006);
    checki("post_reset_latency", lat, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
